// File: rtl/parking_occupancy_if.sv
// Event and status bundle between the lot sensors/supervisor and the occupancy tracker.
interface parking_occupancy_if #(
  parameter int unsigned CNT_W = 5
) ();

  logic             car_in;
  logic             car_out;
  logic             err_clr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] free;
  logic             full;
  logic             empty;
  logic             gate_open;
  logic             overflow_err;
  logic             underflow_err;

  // Event sources and the supervisor.
  modport master (
    output car_in,
    output car_out,
    output err_clr,
    input  count,
    input  free,
    input  full,
    input  empty,
    input  gate_open,
    input  overflow_err,
    input  underflow_err
  );

  // Occupancy tracker.
  modport slave (
    input  car_in,
    input  car_out,
    input  err_clr,
    output count,
    output free,
    output full,
    output empty,
    output gate_open,
    output overflow_err,
    output underflow_err
  );

endinterface

// File: rtl/parking_occupancy.sv
// Parking lot occupancy tracker: counts entry/exit events, drives full/empty flags,
// an entry-gate enable with reopen hysteresis, and sticky overflow/underflow errors.
module parking_occupancy #(
  parameter int unsigned CAPACITY      = 16,
  parameter int unsigned CNT_W         = 5,
  parameter int unsigned REOPEN_MARGIN = 1
) (
  input  logic               clk,
  input  logic               reset,
  parking_occupancy_if.slave bus_io
);

  localparam logic [CNT_W-1:0] CapCnt    = CNT_W'(CAPACITY);
  localparam logic [CNT_W-1:0] ReopenCnt = CNT_W'(CAPACITY - REOPEN_MARGIN);

  typedef enum logic [0:0] {StOpen, StClosed} gate_state_e;

  gate_state_e      state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             in_q, in_d;
  logic             out_q, out_d;
  logic             ev_in, ev_out;
  logic             ovf_set, unf_set;

  // Rising-level detection: a held input is a single car.
  always_comb begin
    ev_in  = bus_io.car_in & ~in_q;
    ev_out = bus_io.car_out & ~out_q;
    in_d   = bus_io.car_in;
    out_d  = bus_io.car_out;
  end

  // Next occupancy and error events; simultaneous entry and exit cancel out.
  always_comb begin
    count_d = count_q;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    case ({ev_in, ev_out})
      2'b10: begin
        if (count_q == CapCnt) ovf_set = 1'b1;
        else                   count_d = count_q + CNT_W'(1);
      end
      2'b01: begin
        if (count_q == '0) unf_set = 1'b1;
        else               count_d = count_q - CNT_W'(1);
      end
      default: ;
    endcase
    full_d  = (count_d == CapCnt);
    empty_d = (count_d == '0);
    // A new error in the clearing cycle keeps the flag set.
    ovf_d   = ovf_set | (ovf_q & ~bus_io.err_clr);
    unf_d   = unf_set | (unf_q & ~bus_io.err_clr);
  end

  // Gate FSM: close when the lot fills, reopen only once enough spaces are free.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StOpen:   if (count_d == CapCnt)    state_d = StClosed;
      StClosed: if (count_d <= ReopenCnt) state_d = StOpen;
      default:  state_d = StOpen;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StOpen;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      in_q    <= 1'b0;
      out_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      in_q    <= in_d;
      out_q   <= out_d;
    end
  end

  // Outputs: everything registered except free, which tracks count directly.
  always_comb begin
    bus_io.count         = count_q;
    bus_io.free          = CapCnt - count_q;
    bus_io.full          = full_q;
    bus_io.empty         = empty_q;
    bus_io.gate_open     = (state_q == StOpen);
    bus_io.overflow_err  = ovf_q;
    bus_io.underflow_err = unf_q;
  end

endmodule

// File: tb/tb_parking_occupancy.sv
// Bench for parking_occupancy: a small-lot instance (4 spaces, reopen margin 2) and a
// default instance share one stimulus stream; a behavioural lot model is compared
// every cycle, and directed literal checks pin the model at key points.
module tb_parking_occupancy;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic car_in = 1'b0;
  logic car_out = 1'b0;
  logic err_clr = 1'b0;

  int n_total = 0;
  int n_pass  = 0;
  bit checking = 1'b0;

  always #5 clk = ~clk;

  parking_occupancy_if #(.CNT_W(5)) if_a ();
  parking_occupancy_if #(.CNT_W(5)) if_b ();

  assign if_a.car_in  = car_in;
  assign if_a.car_out = car_out;
  assign if_a.err_clr = err_clr;
  assign if_b.car_in  = car_in;
  assign if_b.car_out = car_out;
  assign if_b.err_clr = err_clr;

  parking_occupancy #(.CAPACITY(4), .CNT_W(5), .REOPEN_MARGIN(2)) dut_a (
    .clk    (clk),
    .reset  (rst),
    .bus_io (if_a.slave)
  );

  parking_occupancy dut_b (
    .clk    (clk),
    .reset  (rst),
    .bus_io (if_b.slave)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Behavioural lot model: index 0 is the 4-space lot, index 1 the 16-space lot.
  int cap[2]    = '{4, 16};
  int margin[2] = '{2, 1};
  int m_cnt[2]  = '{0, 0};
  bit m_gate[2] = '{1'b1, 1'b1};
  bit m_ovf[2]  = '{1'b0, 1'b0};
  bit m_unf[2]  = '{1'b0, 1'b0};
  bit m_pin = 1'b0;
  bit m_pout = 1'b0;
  bit e_in, e_out;

  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        m_cnt[k] = 0; m_gate[k] = 1'b1; m_ovf[k] = 1'b0; m_unf[k] = 1'b0;
      end
      m_pin  = 1'b0;
      m_pout = 1'b0;
    end else begin
      e_in  = car_in && !m_pin;
      e_out = car_out && !m_pout;
      for (int k = 0; k < 2; k++) begin
        if (err_clr) begin m_ovf[k] = 1'b0; m_unf[k] = 1'b0; end
        if (e_in && !e_out) begin
          if (m_cnt[k] >= cap[k]) m_ovf[k] = 1'b1;
          else m_cnt[k] = m_cnt[k] + 1;
        end else if (e_out && !e_in) begin
          if (m_cnt[k] <= 0) m_unf[k] = 1'b1;
          else m_cnt[k] = m_cnt[k] - 1;
        end
        if (m_cnt[k] == cap[k]) m_gate[k] = 1'b0;
        else if (m_cnt[k] <= cap[k] - margin[k]) m_gate[k] = 1'b1;
      end
      m_pin  = car_in;
      m_pout = car_out;
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (checking) begin
      chk("a.count", int'(if_a.count), m_cnt[0]);
      chk("a.free", int'(if_a.free), cap[0] - m_cnt[0]);
      chk("a.full", int'(if_a.full), int'(m_cnt[0] == cap[0]));
      chk("a.empty", int'(if_a.empty), int'(m_cnt[0] == 0));
      chk("a.gate_open", int'(if_a.gate_open), int'(m_gate[0]));
      chk("a.overflow_err", int'(if_a.overflow_err), int'(m_ovf[0]));
      chk("a.underflow_err", int'(if_a.underflow_err), int'(m_unf[0]));
      chk("b.count", int'(if_b.count), m_cnt[1]);
      chk("b.free", int'(if_b.free), cap[1] - m_cnt[1]);
      chk("b.full", int'(if_b.full), int'(m_cnt[1] == cap[1]));
      chk("b.empty", int'(if_b.empty), int'(m_cnt[1] == 0));
      chk("b.gate_open", int'(if_b.gate_open), int'(m_gate[1]));
      chk("b.overflow_err", int'(if_b.overflow_err), int'(m_ovf[1]));
      chk("b.underflow_err", int'(if_b.underflow_err), int'(m_unf[1]));
    end
  end

  // Apply one cycle of inputs; returns 2 time units after the capturing edge.
  task automatic cyc(input bit ci, input bit co, input bit ec);
    car_in  = ci;
    car_out = co;
    err_clr = ec;
    @(posedge clk);
    #2;
  endtask

  task automatic chk_reset_a(input string tag);
    chk({tag, ".count"}, int'(if_a.count), 0);
    chk({tag, ".free"}, int'(if_a.free), 4);
    chk({tag, ".empty"}, int'(if_a.empty), 1);
    chk({tag, ".full"}, int'(if_a.full), 0);
    chk({tag, ".gate_open"}, int'(if_a.gate_open), 1);
    chk({tag, ".ovf"}, int'(if_a.overflow_err), 0);
    chk({tag, ".unf"}, int'(if_a.underflow_err), 0);
  endtask

  initial begin
    // Reset for two cycles with idle inputs.
    rst = 1'b1;
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk_reset_a("rst");
    chk("rst.b.free", int'(if_b.free), 16);
    chk("rst.b.gate_open", int'(if_b.gate_open), 1);
    checking = 1'b1;
    rst = 1'b0;
    cyc(0, 0, 0);

    // Underflow at zero, then clear.
    cyc(0, 1, 0);
    chk("unf.count", int'(if_a.count), 0);
    chk("unf.flag", int'(if_a.underflow_err), 1);
    cyc(0, 0, 1);
    chk("unf.clr", int'(if_a.underflow_err), 0);

    // Simultaneous entry/exit at zero: no change, no error.
    cyc(1, 1, 0);
    chk("sim0.count", int'(if_a.count), 0);
    chk("sim0.unf", int'(if_a.underflow_err), 0);
    cyc(0, 0, 0);

    // Fill the small lot with four separate pulses.
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0);
      cyc(0, 0, 0);
    end
    chk("fill3.gate", int'(if_a.gate_open), 1);
    cyc(1, 0, 0);
    chk("fill4.count", int'(if_a.count), 4);
    chk("fill4.full", int'(if_a.full), 1);
    chk("fill4.gate", int'(if_a.gate_open), 0);
    chk("fill4.b.gate", int'(if_b.gate_open), 1);
    cyc(0, 0, 0);

    // Simultaneous at capacity.
    cyc(1, 1, 0);
    chk("sim4.count", int'(if_a.count), 4);
    chk("sim4.ovf", int'(if_a.overflow_err), 0);
    cyc(0, 0, 0);

    // Overflow; clear in the same cycle as a new overflow keeps it set.
    cyc(1, 0, 0);
    chk("ovf.count", int'(if_a.count), 4);
    chk("ovf.flag", int'(if_a.overflow_err), 1);
    cyc(0, 0, 0);
    cyc(1, 0, 1);
    chk("ovf.clr_race", int'(if_a.overflow_err), 1);
    cyc(0, 0, 0);
    cyc(0, 0, 1);
    chk("ovf.clr", int'(if_a.overflow_err), 0);
    cyc(0, 0, 0);

    // Hysteresis on the way down.
    cyc(0, 1, 0);
    chk("out1.count", int'(if_a.count), 3);
    chk("out1.gate", int'(if_a.gate_open), 0);
    cyc(0, 0, 0);
    cyc(0, 1, 0);
    chk("out2.count", int'(if_a.count), 2);
    chk("out2.gate", int'(if_a.gate_open), 1);
    cyc(0, 0, 0);

    // Simultaneous at a mid count.
    cyc(1, 1, 0);
    chk("sim2.count", int'(if_a.count), 2);
    cyc(0, 0, 0);

    // Held level from count 1 counts once; a fresh rise counts again.
    cyc(0, 1, 0);
    cyc(0, 0, 0);
    chk("held.start", int'(if_a.count), 1);
    for (int i = 0; i < 5; i++) cyc(1, 0, 0);
    chk("held.count", int'(if_a.count), 2);
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    chk("rerise.count", int'(if_a.count), 3);
    cyc(0, 0, 0);

    // Reach count 3 with the gate closed, then reset mid-operation with car_in high.
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    cyc(0, 1, 0);
    cyc(0, 0, 0);
    chk("pre_rst.count", int'(if_a.count), 3);
    chk("pre_rst.gate", int'(if_a.gate_open), 0);
    rst = 1'b1;
    cyc(1, 0, 0);
    chk_reset_a("mid_rst");
    rst = 1'b0;
    cyc(1, 0, 0);
    chk("post_rst.count", int'(if_a.count), 1);
    chk("post_rst.b.count", int'(if_b.count), 1);
    cyc(0, 0, 0);
    cyc(0, 0, 0);

    checking = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/parking_occupancy.md
# parking_occupancy

Occupancy tracker for the parking lot. It consumes the one-cycle "car entered" pulse from the entry sensor FSM and the matching "car left" pulse from the exit sensor FSM. It maintains the number of occupied spaces, drives full/empty flags and the entry-gate enable with reopen hysteresis, and latches sticky overflow/underflow errors for the supervisor.

## Interface
- `CAPACITY`, default 16: number of spaces; legal range 1 .. 2^CNT_W-1.
- `CNT_W`, default 5: width of `count` and `free`.
- `REOPEN_MARGIN`, default 1: after the lot fills, the gate reopens when `count <= CAPACITY - REOPEN_MARGIN`. Legal range 1 .. CAPACITY.
- `clk`, in, 1: clock.
- `reset`, in, 1: reset, synchronous, active-high.
- `car_in`, in, 1: entry event from the entry FSM; each rising level is one car.
- `car_out`, in, 1: exit event from the exit FSM; each rising level is one car.
- `err_clr`, in, 1: clears `overflow_err` and `underflow_err`.
- `count`, out, CNT_W: occupied spaces (registered).
- `free`, out, CNT_W: `CAPACITY - count` (combinational from `count`).
- `full`, out, 1: `count == CAPACITY` (registered).
- `empty`, out, 1: `count == 0` (registered).
- `gate_open`, out, 1: entry gate enable (registered, from the gate FSM).
- `overflow_err`, out, 1: sticky; an entry was seen while full.
- `underflow_err`, out, 1: sticky; an exit was seen while empty.

## Operation
- **Edge detection.** Registers `in_q` and `out_q` hold the previous sampled `car_in` and `car_out`.
  - `ev_in = car_in & ~in_q` and `ev_out = car_out & ~out_q`.
  - A level held high for N cycles counts as one event.
- **Count update.** Evaluated every cycle that `reset` is low.
  - `ev_in` only, `count < CAPACITY`: `count + 1`.
  - `ev_in` only, `count == CAPACITY`: `count` holds (saturates) and `overflow_err` is set.
  - `ev_out` only, `count > 0`: `count - 1`.
  - `ev_out` only, `count == 0`: `count` holds at 0 and `underflow_err` is set.
  - `ev_in` and `ev_out` together: `count` is unchanged and no error is raised, at any count including 0 and CAPACITY.
  - No event: `count` holds.
- **Flags.** `full` and `empty` are registered from the next-count value, so they change on the same edge as `count`.
- **Gate FSM.** Two states:
  - `OPEN`: `gate_open` = 1. Moves to `CLOSED` when next count == CAPACITY.
  - `CLOSED`: `gate_open` = 0. Moves to `OPEN` when next count <= CAPACITY - REOPEN_MARGIN.
  - With `REOPEN_MARGIN` = 1, `gate_open` is equivalent to `~full`.
- **Errors.**
  - `err_clr` clears both sticky flags.
  - An error event in the same cycle as `err_clr` wins: the flag is set.
- **Reset values.** `count` 0, `full` 0, `empty` 1, `gate_open` 1 (state `OPEN`), both error flags 0, `in_q` 0, `out_q` 0.
  - Consequence of `in_q`/`out_q` resetting to 0: an input held high through reset release counts as one event in the first cycle after reset.
- **Reset mid-operation.** Discards occupancy; the next edge after reset shows the reset values. An event present in the reset cycle is ignored.

## Timing
- Latency: `ev_in`/`ev_out` in cycle t changes `count`, `full`, `empty`, `gate_open` and the error flags at the edge ending cycle t; all are visible in cycle t+1.
- The entry FSM's pulse is one cycle wide, so back-to-back cars yield pulses separated by at least one low cycle. Each such pulse counts.
- Holding an input high across consecutive cycles never produces a second event.
- `free` follows `count` combinationally; there is no additional latency.
- No handshake: events are fire-and-forget, and the block never stalls upstream.

## Test plan
- **Reset:** hold `reset` 2 cycles with `car_in` = 0 and `car_out` = 0 → `count` 0, `free` 16, `empty` 1, `full` 0, `gate_open` 1, both error flags 0.
- **Fill with hysteresis** (CAPACITY = 4, REOPEN_MARGIN = 2):
  - 4 separate `car_in` pulses → `count` 4, `full` 1, `gate_open` 0, both in the cycle after the 4th pulse.
  - One `car_out` pulse → `count` 3, `gate_open` still 0.
  - A second `car_out` pulse → `count` 2, `gate_open` 1.
- **Overflow:** at `count` 4 (CAPACITY = 4), pulse `car_in` → `count` stays 4 and `overflow_err` 1. Then assert `err_clr` together with another `car_in` pulse → `overflow_err` stays 1. Then `err_clr` alone → 0.
- **Underflow / simultaneous:**
  - `car_out` pulse at `count` 0 → `count` 0, `underflow_err` 1.
  - `car_in` and `car_out` in the same cycle at `count` 0, 2 and 4 → `count` unchanged, no error.
- **Held level:** `car_in` high for 5 cycles from `count` 1 → `count` 2 exactly once. Then low 1 cycle and high again → `count` 3.
- **Reset mid-operation:** at `count` 3 with `gate_open` 0 (CAPACITY = 4, REOPEN_MARGIN = 2), assert `reset` for 1 cycle with `car_in` high → all outputs at reset values. `car_in` is still high after release, so `count` becomes 1 in the following cycle.
